// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg: reusable elastic pipeline register between two stages.
//
// Carries a control bundle and a data bundle from an upstream stage to a
// downstream stage. Flush and reset kill every held entry. They also force the
// control bundle to CTRL_SAFE, so a killed instruction can never write the
// register file or memory.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A valid entry stays stable until it is taken. Ready may
// depend on valid, but valid never depends on ready.
//
// Parameters:
//   DATA_W    data bundle width. Only the main copy is cleared on reset.
//   CTRL_W    control bundle width.
//   CTRL_SAFE control value loaded on reset and on flush.
//   SKID      1: main + skid entries, with o_in_ready driven from a flop.
//             0: single entry, with o_in_ready combinational.
//   CNT_W     perf counter width. It exists only with PIPE_STAGE_PERF_EN.
//
// Optional feature (macro PIPE_STAGE_PERF_EN): adds two outputs.
//   o_stall_cnt counts cycles where o_out_valid is high and i_out_ready is low.
//   o_flush_cnt counts valid entries killed by flush.
//
// Ports:
//   i_clk, i_reset       clock (rising edge) and synchronous active-high reset
//   i_flush              kill all held entries on this edge
//   i_in_valid/o_in_ready, i_in_ctrl/i_in_data      upstream side
//   o_out_valid/i_out_ready, o_out_ctrl/o_out_data  downstream side (main entry)
//   o_occupancy          number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W    = 96,
    parameter int                CTRL_W    = 16,
    parameter logic [CTRL_W-1:0] CTRL_SAFE = '0,
    parameter int                SKID      = 1
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int                CNT_W     = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
`endif
);

    // Main entry: always the one presented downstream.
    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid;
    logic              accept;

    // An entry offered during a flush is dropped, even when ready is high.
    assign accept = i_in_valid & o_in_ready & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_SAFE;
            main_data_q  <= '0;
        end else if (i_flush) begin
            // Data is held on flush; only valid and ctrl are made safe.
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_SAFE;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid_q, skid_valid_d;
            logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
            logic [DATA_W-1:0] skid_data_q,  skid_data_d;
            logic              in_ready_q;

            always_comb begin
                main_valid_d = main_valid_q;
                main_ctrl_d  = main_ctrl_q;
                main_data_d  = main_data_q;
                skid_valid_d = skid_valid_q;
                skid_ctrl_d  = skid_ctrl_q;
                skid_data_d  = skid_data_q;
                if (!main_valid_q) begin
                    // The skid entry is never valid while main is empty.
                    if (accept) begin
                        main_valid_d = 1'b1;
                        main_ctrl_d  = i_in_ctrl;
                        main_data_d  = i_in_data;
                    end
                end else if (i_out_ready) begin
                    if (skid_valid_q) begin
                        // No accept is possible here: ready is low while the skid entry is full.
                        main_ctrl_d  = skid_ctrl_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else if (accept) begin
                        main_ctrl_d  = i_in_ctrl;
                        main_data_d  = i_in_data;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    // Downstream stalled: park the new entry in the skid entry.
                    skid_valid_d = 1'b1;
                    skid_ctrl_d  = i_in_ctrl;
                    skid_data_d  = i_in_data;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset || i_flush) begin
                    skid_valid_q <= 1'b0;
                    skid_ctrl_q  <= CTRL_SAFE;
                    in_ready_q   <= 1'b1;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_ctrl_q  <= skid_ctrl_d;
                    skid_data_q  <= skid_data_d;
                    // Ready is registered from the next skid state, so it equals ~skid_valid_q.
                    in_ready_q   <= ~skid_valid_d;
                end
            end

            assign o_in_ready = in_ready_q;
            assign skid_valid = skid_valid_q;
        end else begin : g_noskid
            logic emit;

            assign emit       = main_valid_q & i_out_ready;
            assign o_in_ready = ~main_valid_q | i_out_ready;
            assign skid_valid = 1'b0;

            always_comb begin
                main_valid_d = main_valid_q;
                main_ctrl_d  = main_ctrl_q;
                main_data_d  = main_data_q;
                if (accept) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = i_in_ctrl;
                    main_data_d  = i_in_data;
                end else if (emit) begin
                    main_valid_d = 1'b0;
                end
            end
        end
    endgenerate

    assign o_out_valid = main_valid_q;
    assign o_out_ctrl  = main_ctrl_q;
    assign o_out_data  = main_data_q;
    assign o_occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid};

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters wrap naturally modulo 2^CNT_W.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid_q && !i_out_ready) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (i_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(o_occupancy);
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg: drives one SKID=1 instance and one SKID=0 instance with
// the same upstream and downstream stimulus.
//
// A queue model of held entries is kept for each instance, and every output is
// checked on every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int EW = CW + DW;
    localparam logic [CW-1:0] SAFE = 8'h3C;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNTW = 4;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occ;
    logic          n_in_ready, n_out_valid;
    logic [CW-1:0] n_out_ctrl;
    logic [DW-1:0] n_out_data;
    logic [1:0]    n_occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNTW-1:0] s_stall, s_fcnt, n_stall, n_fcnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_SAFE(SAFE), .SKID(1)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(CNTW)
`endif
    ) u_skid (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(s_in_ready),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data),
        .o_out_valid(s_out_valid), .i_out_ready(out_ready),
        .o_out_ctrl(s_out_ctrl), .o_out_data(s_out_data),
        .o_occupancy(s_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .o_stall_cnt(s_stall), .o_flush_cnt(s_fcnt)
`endif
    );

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_SAFE(SAFE), .SKID(0)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(CNTW)
`endif
    ) u_noskid (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(n_in_ready),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data),
        .o_out_valid(n_out_valid), .i_out_ready(out_ready),
        .o_out_ctrl(n_out_ctrl), .o_out_data(n_out_data),
        .o_occupancy(n_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .o_stall_cnt(n_stall), .o_flush_cnt(n_fcnt)
`endif
    );

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q_s[$];
    logic [EW-1:0] exp_q_n[$];
    logic [CW-1:0] held_ctrl_s, held_ctrl_n;
    logic [DW-1:0] held_data_s, held_data_n;
    int            stall_s, stall_n, fcnt_s, fcnt_n;
    int            checks, errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q_s.delete();
        exp_q_n.delete();
        held_ctrl_s = SAFE; held_data_s = '0;
        held_ctrl_n = SAFE; held_data_n = '0;
        stall_s = 0; stall_n = 0; fcnt_s = 0; fcnt_n = 0;
    endtask

    // Compare every DUT output against the model state before the edge.
    task automatic check_outputs();
        logic [EW-1:0] f;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        // SKID = 1: ready is high while fewer than two entries are held.
        check("s_valid", 32'(s_out_valid), 32'(exp_q_s.size() > 0));
        check("s_occ",   32'(s_occ),       32'(exp_q_s.size()));
        check("s_ready", 32'(s_in_ready),  32'(exp_q_s.size() < 2));
        if (exp_q_s.size() > 0) begin
            f = exp_q_s[0]; ec = f[EW-1:DW]; ed = f[DW-1:0];
        end else begin
            ec = held_ctrl_s; ed = held_data_s;
        end
        check("s_ctrl", 32'(s_out_ctrl), 32'(ec));
        check("s_data", 32'(s_out_data), 32'(ed));
        // SKID = 0: ready is high when empty, or when the head leaves this edge.
        check("n_valid", 32'(n_out_valid), 32'(exp_q_n.size() > 0));
        check("n_occ",   32'(n_occ),       32'(exp_q_n.size()));
        check("n_ready", 32'(n_in_ready),  32'(exp_q_n.size() == 0 || out_ready));
        if (exp_q_n.size() > 0) begin
            f = exp_q_n[0]; ec = f[EW-1:DW]; ed = f[DW-1:0];
        end else begin
            ec = held_ctrl_n; ed = held_data_n;
        end
        check("n_ctrl", 32'(n_out_ctrl), 32'(ec));
        check("n_data", 32'(n_out_data), 32'(ed));
`ifdef PIPE_STAGE_PERF_EN
        check("s_stall", 32'(s_stall), 32'(stall_s));
        check("s_fcnt",  32'(s_fcnt),  32'(fcnt_s));
        check("n_stall", 32'(n_stall), 32'(stall_n));
        check("n_fcnt",  32'(n_fcnt),  32'(fcnt_n));
`endif
    endtask

    // Apply one rising edge to the model, using the inputs driven this cycle.
    task automatic model_edge();
        logic [EW-1:0] f;
        bit acc_s, acc_n, emit_s, emit_n;
        int mask;
        mask   = (1 << 4) - 1;
        acc_s  = in_valid && !flush && exp_q_s.size() < 2;
        acc_n  = in_valid && !flush && (exp_q_n.size() == 0 || out_ready);
        emit_s = exp_q_s.size() > 0 && out_ready;
        emit_n = exp_q_n.size() > 0 && out_ready;
        if (reset) begin
            model_reset();
        end else begin
            if (exp_q_s.size() > 0 && !out_ready) stall_s = (stall_s + 1) & mask;
            if (exp_q_n.size() > 0 && !out_ready) stall_n = (stall_n + 1) & mask;
            if (flush) begin
                fcnt_s = (fcnt_s + exp_q_s.size()) & mask;
                fcnt_n = (fcnt_n + exp_q_n.size()) & mask;
                exp_q_s.delete();
                exp_q_n.delete();
                held_ctrl_s = SAFE;
                held_ctrl_n = SAFE;
            end else begin
                if (emit_s) void'(exp_q_s.pop_front());
                if (emit_n) void'(exp_q_n.pop_front());
                if (acc_s) exp_q_s.push_back({in_ctrl, in_data});
                if (acc_n) exp_q_n.push_back({in_ctrl, in_data});
            end
            if (exp_q_s.size() > 0) begin
                f = exp_q_s[0]; held_ctrl_s = f[EW-1:DW]; held_data_s = f[DW-1:0];
            end
            if (exp_q_n.size() > 0) begin
                f = exp_q_n[0]; held_ctrl_n = f[EW-1:DW]; held_data_n = f[DW-1:0];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Streaming at full rate with downstream always ready.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h05, 16'h000A + 16'(i), 1);
        step(0, 0, 0, 8'h00, 16'h0000, 1);
        step(0, 0, 0, 8'h00, 16'h0000, 1);

        // Downstream stall: A goes to main, B to skid, C waits; then drain.
        step(0, 0, 1, 8'h11, 16'hAAAA, 0);
        step(0, 0, 1, 8'h22, 16'hBBBB, 0);
        step(0, 0, 1, 8'h33, 16'hCCCC, 0);
        step(0, 0, 1, 8'h33, 16'hCCCC, 0);
        step(0, 0, 1, 8'h33, 16'hCCCC, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 16'h0000, 1);

        // Flush while full with all-ones ctrl; the flush-cycle entry is dropped.
        step(0, 0, 1, 8'hFF, 16'h1111, 0);
        step(0, 0, 1, 8'hFF, 16'h2222, 0);
        step(0, 0, 1, 8'hFF, 16'h3333, 0);
        step(0, 1, 1, 8'hFF, 16'h4444, 0);
        step(0, 0, 0, 8'h00, 16'h0000, 1);
        step(0, 0, 0, 8'h00, 16'h0000, 1);

        // Reset while full and stalled; then one entry passes normally.
        step(0, 0, 1, 8'h44, 16'h5555, 0);
        step(0, 0, 1, 8'h55, 16'h6666, 0);
        step(1, 0, 1, 8'h66, 16'h7777, 0);
        step(0, 0, 1, 8'h77, 16'h8888, 1);
        step(0, 0, 0, 8'h00, 16'h0000, 1);
        step(0, 0, 0, 8'h00, 16'h0000, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 0, 8'h00, 16'h0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register that supersedes the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries a control bundle and a data bundle between adjacent stages.
- Uses a valid/ready handshake in place of a bare stall input.
- An optional skid entry gives full throughput with a registered upstream ready.
- Flush kills every held entry and forces the control bundle to a parametrised safe value, so a killed instruction can never write the register file or memory.

Parameters:
DATA_W, 96, width of data bundle (pc, operands, imm, reg indices, ...); no reset/flush clear required.
CTRL_W, 16, width of control bundle (regwrite, memread, memwrite, branch/jump flags, ...).
CTRL_SAFE, '0, value driven into the control bundle on reset and on flush.
SKID, 1, 1 = two-entry (main + skid) with registered o_in_ready; 0 = single entry, combinational o_in_ready.
CNT_W, 32, perf counter width (optional feature only).

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_flush  in  1  kill all held entries this edge.
i_in_valid  in  1  upstream has an entry.
o_in_ready  out  1  block can accept an entry.
i_in_ctrl  in  CTRL_W  upstream control bundle.
i_in_data  in  DATA_W  upstream data bundle.
o_out_valid  out  1  main entry valid.
i_out_ready  in  1  downstream accepts.
o_out_ctrl  out  CTRL_W  main control bundle.
o_out_data  out  DATA_W  main data bundle.
o_occupancy  out  2  number of held entries, 0..2 (0..1 when SKID=0).

Behaviour:
Interface and handshake
- One clock, i_clk. Reset i_reset is synchronous and active-high.
- Accept occurs on an edge where i_in_valid & o_in_ready. Emit occurs on an edge where o_out_valid & i_out_ready.
- Data is presented in order, with no duplication or loss.

Reset (priority 1)
- On the next edge: main_valid = 0, skid_valid = 0, o_out_ctrl = CTRL_SAFE, skid ctrl = CTRL_SAFE, o_out_data = 0, o_occupancy = 0.
- o_in_ready = 1 on the first cycle after reset.

Flush (priority 2)
- Same effect as reset on valid, occupancy and ctrl.
- o_out_data is held, not cleared.
- An upstream entry presented in the flush cycle is dropped, even if o_in_ready = 1.
- Flush during reset has no extra effect.

SKID = 1
- o_in_ready = ~skid_valid, driven from a flop.
- Empty: an accept loads main. Visible next cycle; latency 1.
- Main valid, downstream ready:
  - skid empty: emit, and a simultaneous accept reloads main (throughput 1/cycle);
  - skid full: skid moves to main and skid empties.
- Main valid, downstream not ready: an accept loads skid; o_in_ready falls next cycle.
- Full (occupancy 2): no accept. Output is held stable until emitted.
- Output stability: o_out_ctrl and o_out_data must not change while o_out_valid = 1 and i_out_ready = 0.

SKID = 0
- o_in_ready = ~main_valid | i_out_ready, combinational.
- Accept loads main. The skid flops are not instantiated.

Occupancy and invalid cycles
- o_occupancy = main_valid + skid_valid.
- When o_out_valid = 0, o_out_ctrl equals CTRL_SAFE whenever the cause was reset or flush.
- After a normal drain, ctrl retains the last value and consumers must gate it with o_out_valid.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- When defined, adds output ports:
  - o_stall_cnt[CNT_W]: increments every cycle with o_out_valid & ~i_out_ready.
  - o_flush_cnt[CNT_W]: increments by the number of valid entries killed on each flush edge (0, 1 or 2).
- Both counters clear on i_reset and wrap modulo 2^CNT_W.
- When not defined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
1. Reset, then i_in_valid = 1 with ctrl 0x0005 and data 0xA every cycle, i_out_ready = 1 -> o_out_valid rises 1 cycle after the first accept; one entry emitted per cycle, in order; o_occupancy stays 1.
2. SKID=1: load A, hold i_out_ready = 0, present B then C -> B lands in skid, o_in_ready = 0 next cycle, C is not accepted, o_occupancy = 2. Release i_out_ready -> A, B, C emitted in order.
3. Occupancy 2 with ctrl 0xFFFF, assert i_flush with i_in_valid = 1 -> next cycle o_out_valid = 0, o_occupancy = 0, o_out_ctrl = CTRL_SAFE, o_in_ready = 1; the flush-cycle entry is never emitted.
4. i_reset asserted while full and downstream stalled -> next cycle all outputs at reset values; a subsequent entry passes normally.
5. SKID=0, main valid, i_out_ready toggled 1/0 -> o_in_ready follows ~main_valid | i_out_ready in the same cycle; no entry lost across 100 random ready patterns (scoreboard).
6. PIPE_STAGE_PERF_EN defined: 3 stall cycles, then a flush with occupancy 2 -> o_stall_cnt = 3, o_flush_cnt = 2; with CNT_W = 2, 5 stall cycles wrap to o_stall_cnt = 1.
